addsub_seq_64: RTL and testbench

ADDSUB_SEQ_64 -- requirements
Module: addsub_seq_64

---
 rtl/addsub_seq_64.sv | 129 ++++++++++++
 tb/tb_addsub_seq_64.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_64.sv
// addsub_seq_64: sequential 64-bit adder/subtractor built from one SLICE-wide
// adder, producing one slice per cycle. It computes four slices and then
// presents the result with carry, zero, sign and overflow flags.
module addsub_seq_64 #(
  parameter int SLICE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] Out,
  output logic        cf,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  // state | meaning
  // IDLE  | waiting for start; operands latched when start is seen
  // RUN   | one slice added per cycle, slice index 0..3
  // DONE  | one-cycle completion pulse; Out/flags just loaded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [63:0]    a_q;
  logic [63:0]    b_q;        // B, already inverted for subtraction
  logic [63:0]    acc_q;
  logic           carry_q;
  logic [1:0]     slice_q;

  logic [5:0]     bit_base;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0] sum;
  logic [63:0]    result;
  logic           last_slice;

  // Slice adder and the full result as it stands after the current slice
  always_comb begin
    bit_base   = {slice_q, 4'b0000};
    a_slice    = a_q[bit_base +: SLICE];
    b_slice    = b_q[bit_base +: SLICE];
    sum        = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
    result     = {sum[SLICE-1:0], acc_q[63-SLICE:0]};
    last_slice = (slice_q == 2'd3);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush only matters in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (flush)           state_d = IDLE;
        else if (last_slice) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand latch, slice accumulation and result/flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      slice_q <= '0;
      Out     <= '0;
      cf      <= 1'b0;
      zf      <= 1'b0;
      sf      <= 1'b0;
      of      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= op ? ~B : B;
            carry_q <= op;
            slice_q <= '0;
            acc_q   <= '0;
          end
        end
        RUN: begin
          if (!flush) begin
            acc_q[bit_base +: SLICE] <= sum[SLICE-1:0];
            carry_q                  <= sum[SLICE];
            slice_q                  <= slice_q + 2'd1;
            if (last_slice) begin
              Out <= result;
              cf  <= sum[SLICE];
              zf  <= (result == 64'd0);
              sf  <= result[63];
              // b_q[63] is the original B sign xor op, so this one test
              // covers both the add and subtract overflow rules.
              of  <= (a_q[63] == b_q[63]) && (result[63] != a_q[63]);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_64.sv
// Testbench for addsub_seq_64: directed corner cases, randomized operations
// against an arithmetic reference model, back-to-back, flush and reset.
module tb_addsub_seq_64;

  logic        clk = 1'b0;
  logic        reset, start, op, flush;
  logic [63:0] A, B;
  logic        busy, done, cf, zf, sf, of;
  logic [63:0] Out;

  int checks = 0;
  int errors = 0;
  int last_lat;
  logic last_done2;

  addsub_seq_64 #(.SLICE(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .Out(Out),
    .cf(cf), .zf(zf), .sf(sf), .of(of)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {result, cf, zf, sf, of} from wide arithmetic
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic o_p);
    logic [64:0] r;
    logic c, o;
    if (!o_p) begin
      r = {1'b0, a} + {1'b0, b};
      c = r[64];
      o = (a[63] == b[63]) && (r[63] != a[63]);
    end else begin
      r = {1'b0, a} - {1'b0, b};
      c = ~r[64];                 // no borrow
      o = (a[63] != b[63]) && (r[63] != a[63]);
    end
    return {r[63:0], c, (r[63:0] == 64'd0), r[63], o};
  endfunction

  // Drive one operation, wait for done (bounded), return outputs.
  // last_lat counts cycles with the start cycle as cycle 0.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic o_p,
                        output logic [67:0] res);
    @(negedge clk);
    A = a; B = b; op = o_p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_lat = 1;
    while (done !== 1'b1 && last_lat < 20) begin
      @(negedge clk);
      last_lat++;
    end
    res = {Out, cf, zf, sf, of};
    @(negedge clk);
    last_done2 = done;
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, Out, cf, zf, sf, of} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {busy, done, Out, cf, zf, sf, of});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        o;
    logic [67:0] exp;
  } vec_t;

  task automatic test_directed;
    vec_t v [6];
    logic [67:0] r;
    v[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, {64'h0000_0000_0001_0000, 4'b0000}};
    v[1] = '{64'h0, 64'h1, 1'b1, {64'hFFFF_FFFF_FFFF_FFFF, 4'b0010}};
    v[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, {64'h7FFF_FFFF_FFFF_FFFF, 4'b1001}};
    v[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {64'h8000_0000_0000_0000, 4'b0011}};
    v[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, {64'h0, 4'b1100}};
    v[5] = '{64'h5, 64'h5, 1'b1, {64'h0, 4'b1100}};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].a, v[i].b, v[i].o, r);
      checks++;
      if (last_lat != 5) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected 5", i, last_lat);
      end
      checks++;
      if (r !== v[i].exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, r, v[i].exp);
      end
      checks++;
      if (last_done2 !== 1'b0) begin
        errors++;
        $display("FAIL directed_done_width[%0d]: got %b expected 0", i, last_done2);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] a, b;
    logic o_p;
    logic [67:0] r, e;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      o_p = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = ~a;
        2: b = -a;
        default: ;
      endcase
      e = model(a, b, o_p);
      run_op(a, b, o_p, r);
      checks++;
      if (r !== e || last_lat != 5) begin
        errors++;
        $display("FAIL random[%0d]: got %h lat %0d expected %h lat 5", i, r, last_lat, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a, b;
    logic [67:0] r, e;
    int n;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    e = model(a, b, 1'b0);
    @(negedge clk);
    A = a; B = b; op = 1'b0; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 20);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d expected 5", n);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 20);
      r = {Out, cf, zf, sf, of};
      checks++;
      if (n != 6 || r !== e) begin
        errors++;
        $display("FAIL b2b_period[%0d]: got %0d cycles result %h expected 6 cycles result %h",
                 k, n, r, e);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    // A second start during RUN must be ignored
    e = model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
    @(negedge clk);
    A = 64'h1234_5678_9ABC_DEF0; B = 64'h0FED_CBA9_8765_4321; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = {$urandom, $urandom}; B = {$urandom, $urandom}; op = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    r = {Out, cf, zf, sf, of};
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL start_ignored_result: got %h expected %h", r, e);
    end
    count_dones(10, n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL start_ignored_no_queue: got %0d dones expected 0", n);
    end
  endtask

  task automatic test_flush;
    logic [67:0] r, e;
    int n;
    run_op(64'd3, 64'd4, 1'b0, r);
    checks++;
    if (r[67:4] !== 64'd7) begin
      errors++;
      $display("FAIL flush_pre_add: got %h expected 7", r[67:4]);
    end
    @(negedge clk);
    A = 64'd10; B = 64'd2; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({busy, done, Out, cf, zf, sf, of} !== {2'b00, r}) begin
      errors++;
      $display("FAIL flush_abort: got %h expected %h", {busy, done, Out, cf, zf, sf, of},
               {2'b00, r});
    end
    count_dones(10, n);
    checks++;
    if (n != 0 || Out !== 64'd7) begin
      errors++;
      $display("FAIL flush_no_done: got %0d dones Out %h expected 0 dones Out 7", n, Out);
    end

    // start and flush together in IDLE starts the operation
    e = model(64'd10, 64'd2, 1'b1);
    @(negedge clk);
    A = 64'd10; B = 64'd2; op = 1'b1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_start_idle_busy: got %b expected 1", busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    r = {Out, cf, zf, sf, of};
    checks++;
    if (r !== e || r[67:4] !== 64'd8) begin
      errors++;
      $display("FAIL flush_start_idle_result: got %h expected %h", r, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [67:0] r, e;
    logic [63:0] a, b;
    int n;
    run_op(64'd3, 64'd4, 1'b0, r);
    @(negedge clk);
    A = 64'd10; B = 64'd2; op = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, Out, cf, zf, sf, of} !== 70'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got %h expected 0", {busy, done, Out, cf, zf, sf, of});
    end
    count_dones(10, n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d dones expected 0", n);
    end
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    e = model(a, b, 1'b0);
    run_op(a, b, 1'b0, r);
    checks++;
    if (r !== e) begin
      errors++;
      $display("FAIL first_op_after_reset: got %h expected %h", r, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
